// File: rtl/branch_direction_predictor_if.sv
// rtl/branch_direction_predictor_if.sv - fetch-side lookup and EX-side training bundle for the gshare predictor
interface branch_direction_predictor_if #(
  parameter int GHR_WIDTH = 6
);
  // IF1 lookup: BTB results for the current fetch PC
  logic [31:0]          IF1_pc;
  logic                 IF1_stall;
  logic                 btb_hit;
  logic                 IF1_Branch;
  logic                 IF1_Jump;
  logic [31:0]          pc_imm_in;
  // IF1 prediction results
  logic                 predict_taken;
  logic [31:0]          next_pc;
  logic [GHR_WIDTH-1:0] IF1_pht_idx;
  logic [GHR_WIDTH-1:0] IF1_ghr;
  // EX resolution / training
  logic                 EX_valid;
  logic                 EX_Branch;
  logic                 EX_taken;
  logic                 EX_mispredict;
  logic [GHR_WIDTH-1:0] EX_pht_idx;
  logic [GHR_WIDTH-1:0] EX_ghr;

  modport master (
    output IF1_pc, IF1_stall, btb_hit, IF1_Branch, IF1_Jump, pc_imm_in,
    output EX_valid, EX_Branch, EX_taken, EX_mispredict, EX_pht_idx, EX_ghr,
    input  predict_taken, next_pc, IF1_pht_idx, IF1_ghr
  );

  modport slave (
    input  IF1_pc, IF1_stall, btb_hit, IF1_Branch, IF1_Jump, pc_imm_in,
    input  EX_valid, EX_Branch, EX_taken, EX_mispredict, EX_pht_idx, EX_ghr,
    output predict_taken, next_pc, IF1_pht_idx, IF1_ghr
  );
endinterface

// File: rtl/branch_direction_predictor.sv
// rtl/branch_direction_predictor.sv - gshare direction predictor with speculative history and EX repair
module branch_direction_predictor #(
  parameter int         GHR_WIDTH = 6,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic                    clk,
  input  logic                    rst,
  branch_direction_predictor_if.slave bus
);
  localparam int PHT_DEPTH = 2 ** GHR_WIDTH;

  logic [1:0]           r_pht [PHT_DEPTH];
  logic [GHR_WIDTH-1:0] r_ghr;

  logic [GHR_WIDTH-1:0] w_idx;
  logic                 w_ctr_taken;
  logic                 w_predict;
  logic                 w_spec_shift;
  logic [31:0]          w_pc_seq;
  logic                 w_recover;
  logic                 w_train;
  logic [1:0]           w_ex_ctr;
  logic [1:0]           w_ex_ctr_next;

  // Lookup is purely combinational so the redirect lands in the same cycle as the BTB hit;
  // a line marked both branch and jump falls into the jump term and ignores the counter.
  always_comb begin
    w_idx        = bus.IF1_pc[GHR_WIDTH+1:2] ^ r_ghr;
    w_ctr_taken  = r_pht[w_idx][1];
    w_predict    = bus.btb_hit & (bus.IF1_Jump | (bus.IF1_Branch & w_ctr_taken));
    w_pc_seq     = bus.IF1_pc + 32'd4;
    w_spec_shift = ~bus.IF1_stall & bus.btb_hit & bus.IF1_Branch & ~bus.IF1_Jump;
    w_recover    = bus.EX_valid & bus.EX_mispredict;
    w_train      = bus.EX_valid & bus.EX_Branch;
  end

  assign bus.predict_taken = w_predict;
  assign bus.next_pc       = w_predict ? bus.pc_imm_in : w_pc_seq;
  assign bus.IF1_pht_idx   = w_idx;
  assign bus.IF1_ghr       = r_ghr;

  // Saturating 2-bit counter step for the entry being trained from EX
  always_comb begin
    w_ex_ctr      = r_pht[bus.EX_pht_idx];
    w_ex_ctr_next = w_ex_ctr;
    if (bus.EX_taken) begin
      if (w_ex_ctr != 2'b11) w_ex_ctr_next = w_ex_ctr + 2'b01;
    end else begin
      if (w_ex_ctr != 2'b00) w_ex_ctr_next = w_ex_ctr - 2'b01;
    end
  end

  // Global history: EX repair beats the speculative shift, reset beats both
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_recover) begin
      if (bus.EX_Branch) r_ghr <= {bus.EX_ghr[GHR_WIDTH-2:0], bus.EX_taken};
      else               r_ghr <= bus.EX_ghr;
    end else if (w_spec_shift) begin
      r_ghr <= {r_ghr[GHR_WIDTH-2:0], w_ctr_taken};
    end
  end

  // PHT training; the IF1 read in the same cycle still sees the old counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) r_pht[i] <= CTR_INIT;
    end else if (w_train) begin
      r_pht[bus.EX_pht_idx] <= w_ex_ctr_next;
    end
  end
endmodule

// File: tb/tb_branch_direction_predictor.sv
// tb/tb_branch_direction_predictor.sv - directed bench with a behavioural gshare model
module tb_branch_direction_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  branch_direction_predictor_if #(.GHR_WIDTH(6)) bus ();

  branch_direction_predictor #(.GHR_WIDTH(6), .CTR_INIT(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state: counters as plain integers 0..3, history as an integer 0..63
  int  m_pht [64];
  int  m_ghr = 0;
  bit  m_valid = 1'b0;

  function automatic int m_index();
    return ((bus.IF1_pc >> 2) % 64) ^ m_ghr;
  endfunction

  function automatic bit m_predict();
    if (!bus.btb_hit) return 1'b0;
    if (bus.IF1_Jump) return 1'b1;
    return bus.IF1_Branch && (m_pht[m_index()] >= 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the same edge as the DUT
  always @(posedge clk) begin
    int  idx;
    bit  p;
    bit  spec;
    if (rst) begin
      for (int i = 0; i < 64; i++) m_pht[i] = 1;
      m_ghr   = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      idx  = m_index();
      p    = (m_pht[idx] >= 2);
      spec = !bus.IF1_stall && bus.btb_hit && bus.IF1_Branch && !bus.IF1_Jump;
      if (bus.EX_valid && bus.EX_mispredict)
        m_ghr = bus.EX_Branch ? (((int'(bus.EX_ghr) << 1) | int'(bus.EX_taken)) % 64) : int'(bus.EX_ghr);
      else if (spec)
        m_ghr = ((m_ghr << 1) | int'(p)) % 64;
      if (bus.EX_valid && bus.EX_Branch) begin
        if (bus.EX_taken) m_pht[bus.EX_pht_idx] = (m_pht[bus.EX_pht_idx] == 3) ? 3 : m_pht[bus.EX_pht_idx] + 1;
        else              m_pht[bus.EX_pht_idx] = (m_pht[bus.EX_pht_idx] == 0) ? 0 : m_pht[bus.EX_pht_idx] - 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    #2;
    if (m_valid) begin
      exp_pc = m_predict() ? bus.pc_imm_in : bus.IF1_pc + 32'd4;
      chk("model_predict_taken", {31'd0, bus.predict_taken}, {31'd0, m_predict()});
      chk("model_next_pc", bus.next_pc, exp_pc);
      chk("model_pht_idx", {26'd0, bus.IF1_pht_idx}, m_index());
      chk("model_ghr", {26'd0, bus.IF1_ghr}, m_ghr);
    end
  end

  task automatic if1(input logic [31:0] pc, input logic stall, input logic hit,
                     input logic br, input logic jmp, input logic [31:0] imm);
    bus.IF1_pc = pc; bus.IF1_stall = stall; bus.btb_hit = hit;
    bus.IF1_Branch = br; bus.IF1_Jump = jmp; bus.pc_imm_in = imm;
  endtask

  task automatic ex(input logic v, input logic br, input logic tk, input logic mis,
                    input logic [5:0] idx, input logic [5:0] g);
    bus.EX_valid = v; bus.EX_Branch = br; bus.EX_taken = tk;
    bus.EX_mispredict = mis; bus.EX_pht_idx = idx; bus.EX_ghr = g;
  endtask

  // Advance to the next negedge (inputs change there), then settle for literal checks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    if1(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80);
    ex(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    rst = 1'b1;
    step(); step();

    // 1: after reset, weakly not-taken branch
    rst = 1'b0;
    if1(32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80);
    settle();
    chk("t1_predict", {31'd0, bus.predict_taken}, 32'd0);
    chk("t1_next_pc", bus.next_pc, 32'h104);
    chk("t1_idx", {26'd0, bus.IF1_pht_idx}, 32'h00);
    chk("t1_ghr", {26'd0, bus.IF1_ghr}, 32'h00);

    // 2: train idx 0 taken twice, lookup with stall so history holds
    step(); if1(32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80); ex(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
    step();
    step(); ex(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0); if1(32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80);
    settle();
    chk("t2_predict_11", {31'd0, bus.predict_taken}, 32'd1);
    chk("t2_next_pc", bus.next_pc, 32'h80);
    step(); if1(32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80); ex(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
    step();
    step(); ex(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
    step(); step(); step();
    step(); ex(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0); if1(32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80);
    settle();
    chk("t2_predict_00", {31'd0, bus.predict_taken}, 32'd0);
    // 00 + two taken = 10: proves the counter floored at 00 instead of wrapping
    step(); if1(32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80); ex(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
    step();
    step(); ex(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0); if1(32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80);
    settle();
    chk("t2_predict_10", {31'd0, bus.predict_taken}, 32'd1);

    // 3: jumps, branch+jump line, BTB miss with PC wrap
    step(); if1(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2000);
    settle();
    chk("t3_jump_predict", {31'd0, bus.predict_taken}, 32'd1);
    chk("t3_jump_target", bus.next_pc, 32'h2000);
    chk("t3_jump_idx", {26'd0, bus.IF1_pht_idx}, 32'h3F);
    step(); if1(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000);
    settle();
    chk("t3_brjmp_target", bus.next_pc, 32'h2000);
    step(); if1(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2000);
    settle();
    chk("t3_miss_wrap", bus.next_pc, 32'h0);
    chk("t3_ghr_held", {26'd0, bus.IF1_ghr}, 32'h00);

    // 4: three not-taken predictions, then one taken, then a stalled branch
    step(); if1(32'h104, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80);
    step(); if1(32'h108, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80);
    step(); if1(32'h10C, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80);
    step(); if1(32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80);
    settle();
    chk("t4_ghr_nt", {26'd0, bus.IF1_ghr}, 32'h00);
    step(); if1(32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80);
    settle();
    chk("t4_ghr_shift1", {26'd0, bus.IF1_ghr}, 32'h01);
    step(); if1(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80);
    settle();
    chk("t4_ghr_stall", {26'd0, bus.IF1_ghr}, 32'h01);

    // 5: branch mispredict repair overrides a same-cycle speculative shift
    step(); if1(32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80); ex(1'b1, 1'b1, 1'b1, 1'b1, 6'd5, 6'b101010);
    step(); if1(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80); ex(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    settle();
    chk("t5_ghr_repair", {26'd0, bus.IF1_ghr}, 32'h15);
    step(); ex(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'b101010);
    step(); ex(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    settle();
    chk("t5_ghr_jump_repair", {26'd0, bus.IF1_ghr}, 32'h2A);

    // 6: reset wins over EX training and speculative shift
    step(); rst = 1'b1; if1(32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80); ex(1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 6'b111111);
    step(); rst = 1'b0; ex(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0); if1(32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80);
    settle();
    chk("t6_rst_ghr", {26'd0, bus.IF1_ghr}, 32'h00);
    chk("t6_rst_ctr", {31'd0, bus.predict_taken}, 32'd0);
    // Same-cycle write and read of idx 0: old value now, new value next cycle
    step(); ex(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
    settle();
    chk("t6_old_ctr", {31'd0, bus.predict_taken}, 32'd0);
    step(); ex(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
    settle();
    chk("t6_new_ctr", {31'd0, bus.predict_taken}, 32'd1);
    step(); ex(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
